rx_serial_2lane: RTL and testbench

- Receive-side counterpart of the two-lane serial transmitter.
- Deserializes the bit streams on serial_in_0/serial_in_1 (one bit per clk per lane, MSB first), finds byte alignment from comma symbols and checks that the two lanes agree.
- Un-stripes framed bytes back into 32-bit words with a single-cycle valid strobe, presented to the downstream flop stage.

---
 rtl/rx_serial_2lane.sv | 97 +++++++++
 tb/tb_rx_serial_2lane.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rx_serial_2lane.sv
// rx_serial_2lane: two-lane serial receiver with comma alignment and word un-striping.
// Ports: clk; reset (async, active-low); serial_in_0/1 lane bits (MSB first);
// data_out recovered word {l0 A, l1 A, l0 B, l1 B}; valid_out one-cycle strobe;
// active link locked; error_out one-cycle protocol-violation pulse.
module rx_serial_2lane #(
  parameter logic [7:0] COMMA = 8'hBC,
  parameter logic [7:0] STP = 8'hFB,
  parameter int COMMA_LOCK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_in_0,
  input  logic        serial_in_1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active,
  output logic        error_out
);
  localparam logic [1:0] SEARCH = 2'd0, LOCKING = 2'd1, IDLE = 2'd2, DATA = 2'd3;
  localparam logic [3:0] LOCK_N = 4'(COMMA_LOCK);
  logic [1:0] state;
  logic [7:0] sr0, sr1, a0, a1;
  logic [2:0] cnt;
  logic [3:0] commas;
  logic idx;
  logic boundary, both_comma, both_stp;
  // decisions use the registered shift regs, i.e. one edge after the last bit of a byte
  always_comb begin
    boundary = cnt == 3'd7;
    both_comma = sr0 == COMMA && sr1 == COMMA;
    both_stp = sr0 == STP && sr1 == STP;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= SEARCH;
      sr0 <= '0;
      sr1 <= '0;
      a0 <= '0;
      a1 <= '0;
      cnt <= '0;
      commas <= '0;
      idx <= 1'b0;
      data_out <= '0;
      valid_out <= 1'b0;
      active <= 1'b0;
      error_out <= 1'b0;
    end else begin
      sr0 <= {sr0[6:0], serial_in_0};
      sr1 <= {sr1[6:0], serial_in_1};
      cnt <= cnt + 3'd1;
      valid_out <= 1'b0;
      error_out <= 1'b0;
      case (state)
        SEARCH:
          if (both_comma) begin
            cnt <= '0;
            commas <= 4'd1;
            state <= LOCK_N == 4'd1 ? IDLE : LOCKING;
            active <= LOCK_N == 4'd1;
          end
        LOCKING:
          if (boundary) begin
            if (both_comma) begin
              commas <= commas + 4'd1;
              if (commas == LOCK_N - 4'd1) begin
                state <= IDLE;
                active <= 1'b1;
              end
            end else
              state <= SEARCH;
          end
        IDLE:
          if (boundary && !both_comma) begin
            if (both_stp) begin
              state <= DATA;
              idx <= 1'b0;
            end else begin
              error_out <= 1'b1;
              active <= 1'b0;
              state <= SEARCH;
            end
          end
        default:
          if (boundary) begin
            if (!idx) begin
              a0 <= sr0;
              a1 <= sr1;
              idx <= 1'b1;
            end else begin
              data_out <= {a0, a1, sr0, sr1};
              valid_out <= 1'b1;
              state <= IDLE;
            end
          end
      endcase
    end
endmodule

// File: tb/tb_rx_serial_2lane.sv
// tb_rx_serial_2lane: frame-level scoreboard bench for rx_serial_2lane.
module tb_rx_serial_2lane;
  localparam logic [7:0] COMMA = 8'hBC, STP = 8'hFB;
  logic clk = 1'b0, reset = 1'b0, s0 = 1'b0, s1 = 1'b0;
  logic [31:0] data_out;
  logic valid_out, active, error_out;
  int errs = 0, checks = 0, cyc = 0;
  logic [31:0] exp_v[int];
  bit exp_e[int];
  bit act_ev[int];
  logic exp_act = 1'b0;
  logic [31:0] last_word = '0;
  typedef struct {logic [7:0] s0, s1; logic [31:0] w; bit err;} vec_t;
  vec_t tbl[8];

  rx_serial_2lane dut (
    .clk(clk), .reset(reset), .serial_in_0(s0), .serial_in_1(s1),
    .data_out(data_out), .valid_out(valid_out), .active(active), .error_out(error_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // drive one bit pair, let the edge sample it, then compare every output to the scoreboard
  task automatic tick(input logic b0, input logic b1);
    s0 = b0;
    s1 = b1;
    @(posedge clk);
    cyc++;
    #1;
    if (act_ev.exists(cyc)) exp_act = act_ev[cyc];
    if (exp_v.exists(cyc)) last_word = exp_v[cyc];
    check("valid", 32'(valid_out), 32'(exp_v.exists(cyc)));
    check("data", data_out, last_word);
    check("error", 32'(error_out), 32'(exp_e.exists(cyc)));
    check("active", 32'(active), 32'(exp_act));
  endtask

  task automatic send_pair(input logic [7:0] x, input logic [7:0] y);
    for (int i = 7; i >= 0; i--) tick(x[i], y[i]);
  endtask

  task automatic lock4();
    repeat (4) send_pair(COMMA, COMMA);
    act_ev[cyc + 1] = 1'b1;
  endtask

  task automatic word(input logic [31:0] w);
    send_pair(STP, STP);
    send_pair(w[31:24], w[23:16]);
    send_pair(w[15:8], w[7:0]);
    exp_v[cyc + 1] = w;
  endtask

  task automatic bad(input logic [7:0] x, input logic [7:0] y);
    send_pair(x, y);
    exp_e[cyc + 1] = 1'b1;
    act_ev[cyc + 1] = 1'b0;
  endtask

  function automatic logic [7:0] rbyte();
    int r = $urandom_range(0, 7);
    return r == 0 ? COMMA : r == 1 ? STP : 8'($urandom);
  endfunction

  initial begin
    tbl[0] = '{COMMA, COMMA, 32'h0, 1'b0};
    tbl[1] = '{STP, STP, 32'hA5C30F96, 1'b0};
    tbl[2] = '{STP, COMMA, 32'h0, 1'b1};
    tbl[3] = '{STP, STP, 32'hBCBCFBFB, 1'b0};
    tbl[4] = '{COMMA, STP, 32'h0, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 32'h0, 1'b1};
    tbl[6] = '{STP, STP, 32'h00000001, 1'b0};
    tbl[7] = '{8'hFF, 8'hFF, 32'h0, 1'b1};
    repeat (2) tick(1'($urandom), 1'($urandom));
    reset = 1'b1;
    repeat (40) tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    lock4();
    word(32'hFFFFFFFF);
    repeat (2) send_pair(COMMA, COMMA);
    word(32'hFFFFFFFE);
    word(32'hFFFFFFFD);
    word(32'hBCFBBCFB);
    send_pair(COMMA, COMMA);
    foreach (tbl[k]) begin
      if (tbl[k].err) begin
        bad(tbl[k].s0, tbl[k].s1);
        lock4();
      end else if (tbl[k].s0 == STP) word(tbl[k].w);
      else send_pair(tbl[k].s0, tbl[k].s1);
      send_pair(COMMA, COMMA);
    end
    for (int n = 0; n < 40; n++) begin
      int r = $urandom_range(0, 9);
      if (r < 6) word({rbyte(), rbyte(), rbyte(), rbyte()});
      else if (r < 9) send_pair(COMMA, COMMA);
      else begin
        if ($urandom_range(0, 1) == 1) bad(STP, COMMA);
        else bad(COMMA, STP);
        lock4();
      end
    end
    send_pair(COMMA, COMMA);
    send_pair(STP, STP);
    send_pair(8'h11, 8'h22);
    reset = 1'b0;
    exp_v.delete();
    exp_e.delete();
    act_ev.delete();
    exp_act = 1'b0;
    last_word = '0;
    #1;
    check("async_reset", {valid_out, active, error_out, data_out[28:0]}, 32'h0);
    repeat (3) tick(1'b0, 1'b0);
    reset = 1'b1;
    repeat (5) tick(1'b0, 1'b0);
    lock4();
    word(32'h12345678);
    repeat (2) send_pair(COMMA, COMMA);
    check("final_word", data_out, 32'h12345678);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
